// File: rtl/code_loader_pkg.sv
// Shared types and constants for the J1 code-memory boot loader.
// State encoding, frame sync byte and register widths.
package code_loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

endpackage

// File: rtl/code_loader.sv
// Boot loader: framed byte stream -> 16-bit code RAM writes, holds the
// J1 in reset until a checksum-verified image is in place.
// Ports: clock/resetq, rx_data/rx_valid/rx_ready byte link, start reload
// request, mem_we/mem_address/mem_data RAM write port, cpu_resetq,
// done and error status.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int size       = 'h2000,
  parameter int addr_width = $clog2(size),
  parameter int data_width = 16
) (
  input  logic                  clock,
  input  logic                  resetq,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_address,
  output logic [data_width-1:0] mem_data,
  output logic                  cpu_resetq,
  output logic                  done,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [addr_width-1:0] idx_q, idx_d;
  logic [CSUM_W-1:0]     csum_q, csum_d;
  logic [7:0]            lo_q, lo_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] data_q, data_d;

  logic             accept;
  logic [LEN_W-1:0] len_new;
  logic             last_word;

  assign accept  = rx_valid && rx_ready;
  assign len_new = {rx_data, len_q[7:0]};
  // Length is range-checked before DATA, so N-1 fits the index width.
  assign last_word =
    (idx_q == addr_width'(len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_SYNC: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = S_LEN_LO;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_new;
          if (len_new == '0 || 32'(len_new) > size)
            state_d = S_ERROR;
          else
            state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          csum_d = csum_q + rx_data;
          we_d   = 1'b1;
          addr_d = idx_q;
          data_d = {rx_data, lo_q};
          if (last_word) begin
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DATA_LO;
          end
        end
      end
      S_CSUM: begin
        if (accept)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (start) state_d = S_SYNC;
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign rx_ready    = !(state_q == S_DONE || state_q == S_ERROR);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);
  assign cpu_resetq  = (state_q == S_DONE);

endmodule

// File: tb/tb_code_loader.sv
// Randomized bench for code_loader against a frame-level reference model.
// Expected writes and final status are derived from the frame contents.
module tb_code_loader;

  localparam int SIZE = 'h2000;
  localparam int AW   = $clog2(SIZE);

  logic          clock;
  logic          resetq;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_data;
  logic          cpu_resetq;
  logic          done;
  logic          error;

  code_loader #(.size(SIZE)) dut (
    .clock       (clock),
    .resetq      (resetq),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .start       (start),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .cpu_resetq  (cpu_resetq),
    .done        (done),
    .error       (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] wq[$];
  bit          gaps;

  // Every observed write must match the next expected write in order;
  // an over-long pulse pops twice and shows up as a mismatch.
  always @(negedge clock) begin
    if (resetq && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(w.a));
        chk("wr_data", 32'(mem_data), 32'(w.d));
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit st);
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    start    = st;
    chk("rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad,
                            input bit mid_st, input bit end_st);
    logic [7:0] sum;
    wr_t        w;
    sum = 8'h00;
    push(8'hA5, 1'b0);
    push(8'(n), 1'b0);
    push(8'(n >> 8), 1'b0);
    if (n == 0 || n > SIZE) begin
      chk("len_err", 32'(error), 32'd1);
      chk("len_cpu", 32'(cpu_resetq), 32'd0);
      chk("len_rdy", 32'(rx_ready), 32'd0);
      chk("len_nowe", 32'(mem_we), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      push(wq[i][7:0], mid_st && i == 0);
      w.a = i;
      w.d = wq[i];
      exp_q.push_back(w);
      push(wq[i][15:8], 1'b0);
      sum = sum + wq[i][7:0] + wq[i][15:8];
    end
    push(bad ? sum + 8'd1 : sum, end_st);
    chk("end_done", 32'(done), 32'(!bad));
    chk("end_err", 32'(error), 32'(bad));
    chk("end_cpu", 32'(cpu_resetq), 32'(!bad));
    chk("end_rdy", 32'(rx_ready), 32'd0);
    chk("wr_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("st_cpu", 32'(cpu_resetq), 32'd0);
    chk("st_done", 32'(done), 32'd0);
    chk("st_err", 32'(error), 32'd0);
    chk("st_rdy", 32'(rx_ready), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rdy", 32'(rx_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_cpu", 32'(cpu_resetq), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
  endtask

  task automatic nominal_words();
    wq.delete();
    wq.push_back(16'h1234);
    wq.push_back(16'hABCD);
  endtask

  task automatic random_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
  endtask

  initial begin
    resetq   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    start    = 1'b0;
    gaps     = 1'b0;
    #12;
    chk_reset_vals();
    @(negedge clock);
    resetq = 1'b1;
    @(negedge clock);

    nominal_words();
    send_frame(2, 1'b0, 1'b0, 1'b0);
    do_start();
    send_frame(2, 1'b1, 1'b0, 1'b0);
    do_start();

    send_frame(0, 1'b0, 1'b0, 1'b0);
    do_start();
    send_frame(SIZE + 1, 1'b0, 1'b0, 1'b0);
    do_start();
    send_frame(16'hFFFF, 1'b0, 1'b0, 1'b0);
    do_start();

    gaps = 1'b1;
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    send_frame(2, 1'b0, 1'b1, 1'b0);
    do_start();

    for (int f = 0; f < 6; f++) begin
      int n;
      gaps = 1'($urandom);
      n    = $urandom_range(1, 24);
      random_words(n);
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        push(g, 1'b0);
      end
      send_frame(n, 1'($urandom), 1'($urandom), 1'($urandom));
      do_start();
    end

    gaps = 1'b0;
    random_words(SIZE);
    send_frame(SIZE, 1'b0, 1'b0, 1'b1);
    do_start();

    nominal_words();
    push(8'hA5, 1'b0);
    push(8'h03, 1'b0);
    push(8'h00, 1'b0);
    push(8'h34, 1'b0);
    begin
      wr_t w;
      w.a = 0;
      w.d = 16'h1234;
      exp_q.push_back(w);
    end
    push(8'h12, 1'b0);
    @(negedge clock);
    #2 resetq = 1'b0;
    #1 chk_reset_vals();
    chk("rst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);
    resetq = 1'b1;
    @(negedge clock);
    send_frame(2, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
